// File: rtl/rate_sched_pkg.sv
// rate_sched_pkg: FSM states, rate-select codes and the sel->period map
// shared by rate_scheduler and its bench.
package rate_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  localparam logic [1:0] SEL_FAST = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_3    = 2'b11;

  function automatic longint unsigned sel_period(
    input logic [1:0]        sel,
    input longint unsigned   p1,
    input longint unsigned   p2,
    input longint unsigned   p3
  );
    longint unsigned p;
    p = 64'd1;
    unique case (sel)
      SEL_FAST: p = 64'd1;
      SEL_1:    p = p1;
      SEL_2:    p = p2;
      SEL_3:    p = p3;
      default:  p = 64'd1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rate_scheduler_if.sv
// rate_scheduler_if: requester-side bundle of the shared rate counter.
// master = requesters, slave = scheduler.
interface rate_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 28
);

  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] sel_flat;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               busy;
  logic [CNT_W-1:0]   count_out;

  modport master (
    output req,
    output sel_flat,
    input  grant,
    input  done,
    input  busy,
    input  count_out
  );

  modport slave (
    input  req,
    input  sel_flat,
    output grant,
    output done,
    output busy,
    output count_out
  );

endinterface

// File: rtl/rate_down_counter.sv
// rate_down_counter: loadable down-counter that parks at zero.
// Shared datapath time-sliced by rate_scheduler.
module rate_down_counter
  import rate_sched_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rate_scheduler.sv
// rate_scheduler: round-robin sharing of one rate down-counter.
// Define RATE_SCHED_ABORT_EN to abort a wait when its req drops.
module rate_scheduler
  import rate_sched_pkg::*;
#(
  parameter int          N_REQ   = 4,
  parameter int          CNT_W   = 28,
  parameter int unsigned PERIOD1 = 32'd50000000,
  parameter int unsigned PERIOD2 = 32'd100000000,
  parameter int unsigned PERIOD3 = 32'd200000000
) (
  input  logic           clk,
  input  logic           reset,
  rate_scheduler_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [63:0] CMAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("rate_scheduler: N_REQ must be 2..8");
  end

  if (PERIOD1 < 1 || 64'(PERIOD1) > CMAX ||
      PERIOD2 < 1 || 64'(PERIOD2) > CMAX ||
      PERIOD3 < 1 || 64'(PERIOD3) > CMAX) begin : g_bad_period
    $error("rate_scheduler: period does not fit CNT_W");
  end

  state_t             state, state_n;
  logic [N_REQ-1:0]   grant_q, grant_n;
  logic [N_REQ-1:0]   done_q, done_n;
  logic [PW-1:0]      rr_q, rr_n;
  logic [PW-1:0]      own_q, own_n;
  logic [PW-1:0]      own_nxt;

  logic               found;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand;
  logic [1:0]         sel_a [N_REQ];

  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic               en;
  logic [CNT_W-1:0]   cnt;
  logic               zero;

  for (genvar i = 0; i < N_REQ; i++) begin : g_sel
    assign sel_a[i] = bus.sel_flat[2*i +: 2];
  end

  // first requester at or after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(rr_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign own_nxt = (own_q == LAST) ? '0 : own_q + PW'(1);

  always_comb begin
    state_n  = state;
    grant_n  = grant_q;
    done_n   = '0;
    rr_n     = rr_q;
    own_n    = own_q;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n  = N_REQ'(1) << win;
          own_n    = win;
          load     = 1'b1;
          load_val = CNT_W'(sel_period(sel_a[win], 64'(PERIOD1),
                       64'(PERIOD2), 64'(PERIOD3)) - 64'd1);
          state_n  = COUNT;
        end
      end
      COUNT: begin
`ifdef RATE_SCHED_ABORT_EN
        if (!bus.req[own_q]) begin
          grant_n  = '0;
          load     = 1'b1;
          load_val = '0;
          rr_n     = own_nxt;
          state_n  = IDLE;
        end else
`endif
        if (zero) begin
          done_n  = grant_q;
          state_n = DONE;
        end else begin
          en = 1'b1;
        end
      end
      DONE: begin
        grant_n = '0;
        rr_n    = own_nxt;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      own_q   <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      done_q  <= done_n;
      rr_q    <= rr_n;
      own_q   <= own_n;
    end
  end

  rate_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (cnt),
    .zero     (zero)
  );

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);
  assign bus.count_out = cnt;

endmodule
